// File: rtl/dct_coeff_collector.sv
// -----------------------------------------------------------------------------
// dct_coeff_collector
//
// Receiving end of the DCT serializer's coefficient stream. Each cycle with
// coef_en high carries two indexed coefficients (lanes A and B). They are
// scattered into a 16-slot frame held in one of two ping-pong banks; once
// every slot of the write bank has been written the bank is marked full and
// presented to the consumer as one flat word under a valid/ready handshake,
// while the other bank keeps collecting the next frame.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   coef_en      both lanes valid this cycle (no backpressure to the source)
//   coef_a/idx_a lane A signed coefficient and slot index
//   coef_b/idx_b lane B signed coefficient and slot index (lane A wins on a
//                shared index)
//   frame_flat   read-bank data, slot k at [k*COEF_W +: COEF_W]
//   frame_valid  read bank holds a completed frame
//   frame_ready  consumer accepts the presented frame
//   busy         write bank has at least one filled slot
//   dup_err      sticky: a slot was written twice within a frame
//   ovf_err      sticky: a pair was dropped because both banks were full
//
// Configuration
//   DCT_COLLECT_ERR_EN  when defined, dup_err/ovf_err are live sticky flags;
//                       otherwise the error logic is absent and both read 0.
//
// Parameters: 2**IDX_W must equal NCOEF.
// -----------------------------------------------------------------------------
module dct_coeff_collector #(
    parameter int COEF_W = 18,
    parameter int NCOEF  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_en,
    input  logic signed [COEF_W-1:0] coef_a,
    input  logic [IDX_W-1:0]         idx_a,
    input  logic signed [COEF_W-1:0] coef_b,
    input  logic [IDX_W-1:0]         idx_b,
    output logic [NCOEF*COEF_W-1:0]  frame_flat,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     busy,
    output logic                     dup_err,
    output logic                     ovf_err
);

    // Bank storage and control state
    logic signed [COEF_W-1:0] r_data [2][NCOEF];
    logic [NCOEF-1:0]         r_mask [2];
    logic [1:0]               r_full;
    logic                     r_wr_sel;
    logic                     r_rd_sel;

    logic [NCOEF-1:0] w_onehot_a;
    logic [NCOEF-1:0] w_onehot_b;
    logic [NCOEF-1:0] w_wr_mask;
    logic [NCOEF-1:0] w_mask_next;
    logic             w_wr_ok;
    logic             w_complete;
    logic             w_drain;

    always_comb begin
        w_onehot_a        = '0;
        w_onehot_b        = '0;
        w_onehot_a[idx_a] = 1'b1;
        w_onehot_b[idx_b] = 1'b1;
    end

    assign w_wr_mask   = r_mask[r_wr_sel];
    // Completion looks at the mask with both lanes already merged in.
    assign w_mask_next = w_wr_mask | w_onehot_a | w_onehot_b;
    assign w_wr_ok     = coef_en && !r_full[r_wr_sel];
    assign w_complete  = w_wr_ok && (&w_mask_next);
    assign w_drain     = r_full[r_rd_sel] && frame_ready;

    // Write and drain never target the same bank in one cycle: a write needs
    // its bank not full, a drain needs its bank full. Both may fire together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask[0] <= '0;
            r_mask[1] <= '0;
            r_full    <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
        end else begin
            if (w_drain) begin
                r_mask[r_rd_sel] <= '0;
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
            if (w_wr_ok) begin
                r_mask[r_wr_sel] <= w_mask_next;
                if (w_complete) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end
            end
        end
    end

    // NOTE: the data array is deliberately reset so frame_flat reads 0 out of
    // reset; drains never clear it, only the masks decide slot validity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < NCOEF; k++) begin
                    r_data[b][k] <= '0;
                end
            end
        end else if (w_wr_ok) begin
            // NOTE: with non-blocking assignments the last one to a location
            // takes effect, so lane A is written second to win a shared index.
            r_data[r_wr_sel][idx_b] <= coef_b;
            r_data[r_wr_sel][idx_a] <= coef_a;
        end
    end

    // Read side: the read bank cannot be written while full, so the flat
    // word stays stable for as long as frame_valid is high.
    always_comb begin
        frame_flat = '0;
        for (int k = 0; k < NCOEF; k++) begin
            frame_flat[k*COEF_W +: COEF_W] = r_data[r_rd_sel][k];
        end
    end

    assign frame_valid = r_full[r_rd_sel];
    assign busy        = |r_mask[r_wr_sel];

`ifdef DCT_COLLECT_ERR_EN
    logic r_dup_err;
    logic r_ovf_err;
    logic w_dup_hit;
    logic w_drop;

    // A duplicate is either both lanes sharing an index or a lane landing on
    // a slot already filled in the current write bank.
    assign w_dup_hit = w_wr_ok &&
                       ((idx_a == idx_b) ||
                        (|(w_wr_mask & (w_onehot_a | w_onehot_b))));
    assign w_drop    = coef_en && r_full[r_wr_sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dup_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_dup_hit) r_dup_err <= 1'b1;
            if (w_drop)    r_ovf_err <= 1'b1;
        end
    end

    assign dup_err = r_dup_err;
    assign ovf_err = r_ovf_err;
`else
    assign dup_err = 1'b0;
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_dct_coeff_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dct_coeff_collector: a table of vectors for an
// in-order frame, plus hand-written sequences for reset, scattered writes with
// idle gaps, double-bank backpressure with overflow, duplicate indices and a
// mid-frame reset. Inputs change 1 ns after the rising edge and outputs are
// sampled at that same point, i.e. they show the state after the edge.
// -----------------------------------------------------------------------------
module tb_dct_coeff_collector;

    localparam int COEF_W = 18;
    localparam int NCOEF  = 16;
    localparam int IDX_W  = 4;

`ifdef DCT_COLLECT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     coef_en;
    logic signed [COEF_W-1:0] coef_a;
    logic [IDX_W-1:0]         idx_a;
    logic signed [COEF_W-1:0] coef_b;
    logic [IDX_W-1:0]         idx_b;
    logic [NCOEF*COEF_W-1:0]  frame_flat;
    logic                     frame_valid;
    logic                     frame_ready;
    logic                     busy;
    logic                     dup_err;
    logic                     ovf_err;

    dct_coeff_collector #(
        .COEF_W (COEF_W),
        .NCOEF  (NCOEF),
        .IDX_W  (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coef_en     (coef_en),
        .coef_a      (coef_a),
        .idx_a       (idx_a),
        .coef_b      (coef_b),
        .idx_b       (idx_b),
        .frame_flat  (frame_flat),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .dup_err     (dup_err),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        int ia;
        int ib;
        int ca;
        int cb;
        bit rdy;
        bit exp_valid;
        bit exp_busy;
        int s0;      // slot to inspect, -1 for none
        int s0_exp;
        int s1;
        int s1_exp;
    } vec_t;

    vec_t tbl [10];

    int n_checks = 0;
    int n_fail   = 0;

    // Scattered order: every slot exactly once, lanes far apart.
    int scat_a [8] = '{15, 7, 1, 2, 3, 4, 5, 6};
    int scat_b [8] = '{0, 8, 14, 13, 12, 11, 10, 9};
    // Fill of every slot except 3 and 4.
    int fill_a [7] = '{0, 2, 6, 8, 10, 12, 14};
    int fill_b [7] = '{1, 5, 7, 9, 11, 13, 15};

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint slot(input int k);
        logic signed [COEF_W-1:0] v;
        v = frame_flat[k*COEF_W +: COEF_W];
        return longint'(v);
    endfunction

    task automatic step(input bit en, input int ia, input int ib,
                        input int ca, input int cb);
        coef_en = en;
        idx_a   = ia[IDX_W-1:0];
        idx_b   = ib[IDX_W-1:0];
        coef_a  = ca[COEF_W-1:0];
        coef_b  = cb[COEF_W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        // ---------------- reset with traffic present ----------------
        reset       = 1'b0;
        frame_ready = 1'b1;
        coef_en     = 1'b1;
        idx_a       = 4'd2;
        idx_b       = 4'd3;
        coef_a      = 18'sd77;
        coef_b      = 18'sd78;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", longint'(frame_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_flat", longint'(|frame_flat), 0);
        check("rst_dup", longint'(dup_err), 0);
        check("rst_ovf", longint'(ovf_err), 0);
        coef_en = 1'b0;
        reset   = 1'b1;
        idle();
        idle();
        check("post_rst_valid", longint'(frame_valid), 0);
        check("post_rst_busy", longint'(busy), 0);

        // ---------------- in-order frame, table driven ----------------
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 2*i, 2*i+1, -100*(2*i), -100*(2*i+1), 1'b1,
                       (i == 7), (i != 7),
                       (i == 7) ? 7 : -1, -700,
                       (i == 7) ? 0 : -1, 0};
        end
        tbl[8] = '{1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0};
        tbl[9] = '{1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, -1, 0, -1, 0};
        for (int i = 0; i < 10; i++) begin
            frame_ready = tbl[i].rdy;
            step(tbl[i].en, tbl[i].ia, tbl[i].ib, tbl[i].ca, tbl[i].cb);
            check($sformatf("ord_valid[%0d]", i), longint'(frame_valid), longint'(tbl[i].exp_valid));
            check($sformatf("ord_busy[%0d]", i), longint'(busy), longint'(tbl[i].exp_busy));
            if (tbl[i].s0 >= 0)
                check($sformatf("ord_slot%0d", tbl[i].s0), slot(tbl[i].s0), longint'(tbl[i].s0_exp));
            if (tbl[i].s1 >= 0)
                check($sformatf("ord_slot%0d", tbl[i].s1), slot(tbl[i].s1), longint'(tbl[i].s1_exp));
        end

        // ---------------- scattered order with idle gaps ----------------
        frame_ready = 1'b0;
        for (int p = 0; p < 8; p++) begin
            step(1'b1, scat_a[p], scat_b[p], 1000 + scat_a[p], 1000 + scat_b[p]);
            check($sformatf("scat_valid[%0d]", p), longint'(frame_valid), longint'(p == 7));
            check($sformatf("scat_busy[%0d]", p), longint'(busy), longint'(p != 7));
            if (p < 7) begin
                repeat (3) idle();
                check($sformatf("scat_gap_valid[%0d]", p), longint'(frame_valid), 0);
            end
        end
        for (int k = 0; k < NCOEF; k++)
            check($sformatf("scat_slot%0d", k), slot(k), longint'(1000 + k));
        frame_ready = 1'b1;
        idle();
        check("scat_drain_valid", longint'(frame_valid), 0);
        check("scat_drain_busy", longint'(busy), 0);

        // ---------------- backpressure: two held, third dropped ----------------
        frame_ready = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < 8; i++)
                step(1'b1, 2*i, 2*i+1, f*100 + 2*i, f*100 + 2*i + 1);
            check($sformatf("bp_valid_f%0d", f), longint'(frame_valid), 1);
        end
        check("bp_busy_full", longint'(busy), 1);
        check("bp_ovf", longint'(ovf_err), longint'(ERR_EN));
        check("bp_dup_clean", longint'(dup_err), 0);
        check("bp_f1_slot5", slot(5), 105);
        check("bp_f1_slot15", slot(15), 115);
        frame_ready = 1'b1;
        idle();
        check("bp_f2_valid", longint'(frame_valid), 1);
        check("bp_f2_slot5", slot(5), 205);
        check("bp_f2_slot0", slot(0), 200);
        idle();
        check("bp_end_valid", longint'(frame_valid), 0);
        check("bp_end_busy", longint'(busy), 0);

        // ---------------- duplicate: lane A wins ----------------
        frame_ready = 1'b0;
        step(1'b1, 3, 3, 5, 9);
        check("dup_flag", longint'(dup_err), longint'(ERR_EN));
        check("dup_busy", longint'(busy), 1);
        for (int j = 0; j < 7; j++)
            step(1'b1, fill_a[j], fill_b[j], 50 + fill_a[j], 50 + fill_b[j]);
        check("dup1_not_done", longint'(frame_valid), 0);
        step(1'b1, 4, 4, -4, 0);
        check("dup1_valid", longint'(frame_valid), 1);
        check("dup1_slot3", slot(3), 5);
        check("dup1_slot4", slot(4), -4);
        frame_ready = 1'b1;
        idle();
        frame_ready = 1'b0;

        // ---------------- duplicate then rewrite of slot 3 ----------------
        step(1'b1, 3, 3, 5, 9);
        step(1'b1, 3, 4, 11, -4);
        for (int j = 0; j < 7; j++) begin
            step(1'b1, fill_a[j], fill_b[j], 50 + fill_a[j], 50 + fill_b[j]);
            check($sformatf("dup2_valid[%0d]", j), longint'(frame_valid), longint'(j == 6));
        end
        check("dup2_slot3", slot(3), 11);
        check("dup2_slot4", slot(4), -4);
        check("dup2_slot0", slot(0), 50);
        check("dup2_slot15", slot(15), 65);
        frame_ready = 1'b1;
        idle();
        check("dup2_drain_valid", longint'(frame_valid), 0);
        check("dup_sticky", longint'(dup_err), longint'(ERR_EN));

        // ---------------- mid-frame reset ----------------
        frame_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            step(1'b1, 2*i, 2*i+1, 600 + 2*i, 600 + 2*i + 1);
        check("mid_busy_pre", longint'(busy), 1);
        coef_en = 1'b0;
        reset   = 1'b0;
        #2;
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_valid", longint'(frame_valid), 0);
        check("mid_rst_flat", longint'(|frame_flat), 0);
        check("mid_rst_dup", longint'(dup_err), 0);
        check("mid_rst_ovf", longint'(ovf_err), 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2*i, 2*i+1, 700 + 2*i, 700 + 2*i + 1);
            check($sformatf("mid_valid[%0d]", i), longint'(frame_valid), longint'(i == 7));
        end
        check("mid_slot0", slot(0), 700);
        check("mid_slot9", slot(9), 709);
        check("mid_slot15", slot(15), 715);
        frame_ready = 1'b1;
        idle();
        check("mid_drain_valid", longint'(frame_valid), 0);
        check("mid_drain_busy", longint'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
